// File: rtl/text_plane_controller.sv
`default_nettype none
// ============================================================================
// Module   : text_plane_controller
// Purpose  : Arbitrates two character sources into the character-plane write
//            port, tracks the cursor and runs the line/screen clear engines.
//            Optional macro TEXT_PLANE_CURSOR_BLINK_EN adds output cursor_vis.
// Revision : 1.0 - initial release
// ============================================================================
module text_plane_controller #(
  parameter int COLS      = 80,
  parameter int ROWS      = 30,
  parameter int COL_W     = 7,
  parameter int ROW_W     = 5,
  parameter int BLINK_DIV = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [7:0]       req0_char,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_char,
  output logic             req1_ready,
  input  logic             clr,
  output logic             busy,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [7:0]       wr_char,
  output logic [ROW_W-1:0] cur_row,
`ifdef TEXT_PLANE_CURSOR_BLINK_EN
  output logic             cursor_vis,
`endif
  output logic [COL_W-1:0] cur_col
);

  localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [7:0]       c_SPACE    = 8'h20;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_LINE = 2'd1,
    CLR_ALL  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_clr_pend;
  logic             r_rr;          // 1: req1 wins a tie next time
  logic [ROW_W-1:0] r_cur_row;
  logic [COL_W-1:0] r_cur_col;
  logic [ROW_W-1:0] r_sw_row;
  logic [COL_W-1:0] r_sw_col;
  logic             r_wr_en;
  logic [ROW_W-1:0] r_wr_row;
  logic [COL_W-1:0] r_wr_col;
  logic [7:0]       r_wr_char;

  logic       w_open;
  logic       w_grant1;
  logic       w_accept;
  logic [7:0] w_char;
  logic       w_printable;
  logic       w_newline;
  logic       w_backspace;
  logic       w_col_last;
  logic       w_row_last;
  logic       w_line_adv;

  assign w_open      = (r_state == IDLE) && !r_clr_pend;
  assign w_grant1    = req1_valid && (!req0_valid || r_rr);
  assign req1_ready  = w_open && w_grant1;
  assign req0_ready  = w_open && req0_valid && !w_grant1;
  assign w_accept    = req0_ready || req1_ready;
  assign w_char      = req1_ready ? req1_char : req0_char;
  assign w_printable = (w_char >= 8'h20) && (w_char <= 8'h7E);
  assign w_newline   = (w_char == 8'h0A) || (w_char == 8'h0D);
  assign w_backspace = (w_char == 8'h08) && (r_cur_col != '0);
  assign w_col_last  = (r_cur_col == c_COL_LAST);
  assign w_row_last  = (r_cur_row == c_ROW_LAST);
  assign w_line_adv  = (w_printable && w_col_last) || w_newline;

  assign busy    = (r_state != IDLE) || r_clr_pend;
  assign wr_en   = r_wr_en;
  assign wr_row  = r_wr_row;
  assign wr_col  = r_wr_col;
  assign wr_char = r_wr_char;
  assign cur_row = r_cur_row;
  assign cur_col = r_cur_col;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_clr_pend <= 1'b0;
      r_rr       <= 1'b0;
      r_cur_row  <= '0;
      r_cur_col  <= '0;
      r_sw_row   <= '0;
      r_sw_col   <= '0;
      r_wr_en    <= 1'b0;
      r_wr_row   <= '0;
      r_wr_col   <= '0;
      r_wr_char  <= '0;
    end else begin
      r_wr_en <= 1'b0;
      // A clear during the full sweep is redundant and is dropped.
      if (clr && r_state != CLR_ALL) r_clr_pend <= 1'b1;
      case (r_state)
        IDLE: begin
          if (r_clr_pend) begin
            r_clr_pend <= 1'b0;
            r_state    <= CLR_ALL;
            r_sw_row   <= '0;
            r_sw_col   <= '0;
          end else if (w_accept) begin
            r_rr <= req0_ready;
            if (w_printable) begin
              r_wr_en   <= 1'b1;
              r_wr_row  <= r_cur_row;
              r_wr_col  <= r_cur_col;
              r_wr_char <= w_char;
              if (!w_col_last) r_cur_col <= r_cur_col + 1'b1;
            end else if (w_backspace) begin
              r_wr_en   <= 1'b1;
              r_wr_row  <= r_cur_row;
              r_wr_col  <= r_cur_col - 1'b1;
              r_wr_char <= c_SPACE;
              r_cur_col <= r_cur_col - 1'b1;
            end
            if (w_line_adv) begin
              r_cur_col <= '0;
              if (w_row_last) begin
                r_cur_row <= '0;
                r_state   <= CLR_LINE;
                r_sw_col  <= '0;
              end else begin
                r_cur_row <= r_cur_row + 1'b1;
              end
            end
          end
        end
        CLR_LINE: begin
          r_wr_en   <= 1'b1;
          r_wr_row  <= r_cur_row;
          r_wr_col  <= r_sw_col;
          r_wr_char <= c_SPACE;
          if (r_sw_col == c_COL_LAST) r_state <= IDLE;
          else r_sw_col <= r_sw_col + 1'b1;
        end
        CLR_ALL: begin
          r_wr_en   <= 1'b1;
          r_wr_row  <= r_sw_row;
          r_wr_col  <= r_sw_col;
          r_wr_char <= c_SPACE;
          if (r_sw_col == c_COL_LAST) begin
            r_sw_col <= '0;
            if (r_sw_row == c_ROW_LAST) begin
              r_state   <= IDLE;
              r_cur_row <= '0;
              r_cur_col <= '0;
            end else begin
              r_sw_row <= r_sw_row + 1'b1;
            end
          end else begin
            r_sw_col <= r_sw_col + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef TEXT_PLANE_CURSOR_BLINK_EN
  localparam int c_BLINK_W = $clog2(BLINK_DIV + 1);

  logic [c_BLINK_W-1:0] r_blink_cnt;
  logic [c_BLINK_W-1:0] r_solid_cnt;
  logic                 r_blink;
  logic [ROW_W-1:0]     r_prev_row;
  logic [COL_W-1:0]     r_prev_col;
  logic                 w_moved;

  assign w_moved    = (r_prev_row != r_cur_row) || (r_prev_col != r_cur_col);
  assign cursor_vis = !busy && (r_blink || (r_solid_cnt != '0));

  // Solid window restarts on every cursor move so typing never blinks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blink_cnt <= '0;
      r_solid_cnt <= '0;
      r_blink     <= 1'b1;
      r_prev_row  <= '0;
      r_prev_col  <= '0;
    end else begin
      r_prev_row <= r_cur_row;
      r_prev_col <= r_cur_col;
      if (r_blink_cnt == c_BLINK_W'(BLINK_DIV - 1)) begin
        r_blink_cnt <= '0;
        r_blink     <= !r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
      if (w_moved) r_solid_cnt <= c_BLINK_W'(BLINK_DIV);
      else if (r_solid_cnt != '0) r_solid_cnt <= r_solid_cnt - 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_text_plane_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_plane_controller
// Purpose  : Scoreboard bench for text_plane_controller; expected plane writes
//            are queued by the stimulus and popped by a write monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_text_plane_controller;

  localparam int c_COLS  = 80;
  localparam int c_ROWS  = 30;
  localparam int c_COL_W = 7;
  localparam int c_ROW_W = 5;

  typedef struct packed {
    logic [c_ROW_W-1:0] row;
    logic [c_COL_W-1:0] col;
    logic [7:0]         ch;
  } wr_t;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               req0_valid = 1'b0;
  logic [7:0]         req0_char = 8'h00;
  logic               req0_ready;
  logic               req1_valid = 1'b0;
  logic [7:0]         req1_char = 8'h00;
  logic               req1_ready;
  logic               clr = 1'b0;
  logic               busy;
  logic               wr_en;
  logic [c_ROW_W-1:0] wr_row;
  logic [c_COL_W-1:0] wr_col;
  logic [7:0]         wr_char;
  logic [c_ROW_W-1:0] cur_row;
  logic [c_COL_W-1:0] cur_col;
`ifdef TEXT_PLANE_CURSOR_BLINK_EN
  logic               cursor_vis;
`endif

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  sb_en  = 1'b1;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  text_plane_controller #(
    .COLS(c_COLS), .ROWS(c_ROWS), .COL_W(c_COL_W), .ROW_W(c_ROW_W), .BLINK_DIV(16)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_char(req0_char), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_char(req1_char), .req1_ready(req1_ready),
    .clr(clr), .busy(busy),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_char(wr_char),
    .cur_row(cur_row),
`ifdef TEXT_PLANE_CURSOR_BLINK_EN
    .cursor_vis(cursor_vis),
`endif
    .cur_col(cur_col)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int row, input int col, input logic [7:0] ch);
    wr_t e;
    e.row = c_ROW_W'(row);
    e.col = c_COL_W'(col);
    e.ch  = ch;
    exp_q.push_back(e);
  endtask

  task automatic check_cursor(input string name, input int row, input int col);
    check({name, "_row"}, int'(cur_row), row);
    check({name, "_col"}, int'(cur_col), col);
  endtask

  // Offer one char on source 0 and wait (bounded) for its acceptance.
  task automatic send0(input logic [7:0] c);
    int k;
    k = 0;
    req0_valid = 1'b1;
    req0_char  = c;
    #1;
    while (!req0_ready && k < 5000) begin
      step();
      #1;
      k++;
    end
    check("send0_ready", int'(req0_ready), 1);
    step();
    req0_valid = 1'b0;
  endtask

  task automatic do_reset();
    check("queue_drained", exp_q.size(), 0);
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset && wr_en && sb_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_row", int'(wr_row), int'(e.row));
          check("wr_col", int'(wr_col), int'(e.col));
          check("wr_char", int'(wr_char), int'(e.ch));
        end
      end
    end
  endtask

  initial begin
    int cnt;
    fork
      monitor();
      begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset values
    #3;
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_busy", int'(busy), 0);
    check_cursor("rst_cursor", 0, 0);
    step();
    reset = 1'b1;

    // Single char from reset
    push(0, 0, 8'h41);
    check("a_req1_ready", int'(req1_ready), 0);
    send0(8'h41);
    check_cursor("a_cursor", 0, 1);

    // Round-robin with both sources valid every cycle
    step();
    do_reset();
    req0_valid = 1'b1; req0_char = 8'h78;
    req1_valid = 1'b1; req1_char = 8'h79;
    push(0, 0, 8'h78); push(0, 1, 8'h79); push(0, 2, 8'h78); push(0, 3, 8'h79);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ready0", int'(req0_ready), (i % 2 == 0) ? 1 : 0);
      check("rr_ready1", int'(req1_ready), (i % 2 == 1) ? 1 : 0);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_cursor("rr_cursor", 0, 4);

    // Full row, wrap, backspace at col 0 and col 1, ignored and CR codes
    step();
    do_reset();
    for (int i = 0; i < c_COLS; i++) begin
      push(0, i, 8'h61 + 8'(i % 26));
      send0(8'h61 + 8'(i % 26));
    end
    check_cursor("row_wrap", 1, 0);
    send0(8'h08);
    check_cursor("bs_col0", 1, 0);
    push(1, 0, 8'h51);
    send0(8'h51);
    check_cursor("q_cursor", 1, 1);
    push(1, 0, 8'h20);
    send0(8'h08);
    check_cursor("bs_col1", 1, 0);
    send0(8'h01);
    check_cursor("ignored", 1, 0);
    send0(8'h0D);
    check_cursor("cr", 2, 0);

    // Walk to (29,5) then newline triggers the line clear of row 0
    for (int i = 0; i < 27; i++) send0(8'h0A);
    for (int i = 0; i < 5; i++) begin
      push(29, i, 8'h30 + 8'(i));
      send0(8'h30 + 8'(i));
    end
    check_cursor("pre_nl", 29, 5);
    for (int i = 0; i < c_COLS; i++) push(0, i, 8'h20);
    send0(8'h0A);
    check("nl_busy", int'(busy), 1);
    check_cursor("nl_cursor", 0, 0);
    cnt = 0;
    while (busy && cnt < 1000) begin
      check("line_ready_low", int'(req0_ready || req1_ready), 0);
      step();
      cnt++;
    end
    check("line_busy_cycles", cnt, 80);
    push(0, 0, 8'h5A);
    send0(8'h5A);
    check_cursor("after_line", 0, 1);

    // Full clear with req0 held, plus an extra clr mid-sweep
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_busy", int'(busy), 1);
    for (int r = 0; r < c_ROWS; r++)
      for (int c = 0; c < c_COLS; c++) push(r, c, 8'h20);
    push(0, 0, 8'h4B);
    req0_valid = 1'b1;
    req0_char  = 8'h4B;
    #1;
    cnt = 0;
    while (!req0_ready && cnt < 3000) begin
      clr = (cnt == 100);
      step();
      clr = 1'b0;
      #1;
      cnt++;
    end
    check("clr_all_cycles", cnt, 2401);
    check_cursor("clr_cursor", 0, 0);
    step();
    req0_valid = 1'b0;
    check_cursor("after_clr", 0, 1);

    // Reset in the middle of a full clear
    repeat (2) step();
    check("queue_before_abort", exp_q.size(), 0);
    sb_en = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (100) step();
    check("mid_sweep_wr_en", int'(wr_en), 1);
    reset = 1'b0;
    #1;
    check("abort_wr_en", int'(wr_en), 0);
    check("abort_busy", int'(busy), 0);
    check_cursor("abort_cursor", 0, 0);
    step();
    reset = 1'b1;
    exp_q.delete();
    sb_en = 1'b1;
    check("post_abort_wr_en", int'(wr_en), 0);
    push(0, 0, 8'h52);
    send0(8'h52);
    check_cursor("post_abort_cursor", 0, 1);

    repeat (3) step();
    check("queue_final", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/text_plane_controller.md
Name: text_plane_controller

Overview:
- Sequences all writes into the character plane's write port on behalf of two character sources: req0 (keyboard/UART path) and req1 (on-board switches/buttons feeder).
- Round-robin arbitration between the two sources, cursor tracking, and control-code interpretation (newline, backspace).
- Background line-clear and screen-clear engines that own the write port while they run.
- Sits between the input feeders and the character plane; the VGA pixel path reads the plane independently.

Parameters:
- COLS, 80, characters per row (640 px / 8 px glyph)
- ROWS, 30, character rows (480 px / 16 px glyph)
- COL_W, 7, column index width; 2^COL_W >= COLS
- ROW_W, 5, row index width; 2^ROW_W >= ROWS
- BLINK_DIV, 25000000, cursor blink half-period in clk cycles (optional feature only)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req0_valid  in  1  source 0 has a character
- req0_char  in  8  source 0 character code
- req0_ready  out  1  source 0 character accepted this cycle when valid&ready
- req1_valid  in  1  source 1 has a character
- req1_char  in  8  source 1 character code
- req1_ready  out  1  source 1 accept
- clr  in  1  single-cycle request to clear the whole screen
- busy  out  1  a clear engine is running, or a clear is pending
- wr_en  out  1  character plane write strobe
- wr_row  out  ROW_W  write row
- wr_col  out  COL_W  write column
- wr_char  out  8  write data
- cur_row  out  ROW_W  current cursor row
- cur_col  out  COL_W  current cursor column

Behaviour:
- Reset (reset=0, asynchronous) values:
  - state=IDLE
  - cursor (0,0)
  - wr_en=0, wr_row=0, wr_col=0, wr_char=0
  - busy=0, clr_pend=0
  - rr pointer=0, so req0 is preferred first
- States: IDLE, CLR_LINE, CLR_ALL.
- Ready rules:
  - reqN_ready is combinational and is 1 only in IDLE, with clr_pend=0, to the granted source.
  - Grant: if only one source is valid, it is granted. If both are valid, the source other than the last-accepted one is granted. The rr pointer updates on every accept.
  - At most one ready is high per cycle.
- Character handling: acceptance happens in cycle N. wr_* are registered outputs; the write appears in cycle N+1 for exactly one cycle.
  - 0x20..0x7E: write the char at the cursor, then col+1. When col reaches COLS, set col=0 and row+1.
  - 0x0A or 0x0D: no write; col=0, row+1.
  - 0x08: if col>0, col-1 and write 0x20 at the new col. If col=0, no write and no move; backspace never crosses rows.
  - Any other code is consumed and ignored; no write, no cursor change.
- Row advance:
  - If row+1 < ROWS, row increments.
  - Otherwise row wraps to 0, and the state enters CLR_LINE at the next cycle with cursor (0,0).
- CLR_LINE:
  - Writes 0x20 to (cur_row, 0..COLS-1), one cell per cycle, wr_en held high for COLS consecutive cycles.
  - Returns to IDLE; busy=1 throughout.
- clr handling:
  - clr=1 in any state sets clr_pend.
  - In IDLE, clr_pend has priority over both sources (no ready issued that cycle). The state enters CLR_ALL and clr_pend clears.
  - A clr arriving during CLR_ALL is absorbed; the sweep continues and does not restart.
  - A clr arriving during CLR_LINE is held pending and taken after CLR_LINE returns to IDLE.
- CLR_ALL:
  - Writes 0x20 to every cell in row-major order: (0,0)..(ROWS-1,COLS-1), ROWS*COLS cycles, wr_en continuous.
  - Then cursor=(0,0), state returns to IDLE.
- busy = (state != IDLE) | clr_pend.
- Cursor range invariant: cur_row < ROWS, cur_col < COLS at all times.
- Reset mid-clear aborts immediately to the reset values. Any in-flight write is dropped.

Optional Feature:
- Macro: TEXT_PLANE_CURSOR_BLINK_EN
- Defined:
  - Adds output cursor_vis (1 bit).
  - A counter toggles cursor_vis every BLINK_DIV cycles.
  - cursor_vis is forced to 1 for BLINK_DIV cycles after any cursor move, so the cursor is solid while typing.
  - cursor_vis is 0 while busy=1.
  - Reset value of cursor_vis is 1.
- Undefined:
  - No cursor_vis port, no counter.
  - All other behaviour is identical.

Test Plan:
- req0 sends 'A'(0x41) from reset -> req0_ready=1 in cycle N; wr_en=1, (0,0), 0x41 in cycle N+1; cursor (0,1).
- Both valid every cycle, req0='x', req1='y', 4 accepts -> accept order req0,req1,req0,req1; writes to cols 0..3 = x,y,x,y.
- 80 printable chars then 0x08 -> cursor (1,0) after the 80th char; the backspace gives no write and the cursor stays (1,0).
- Cursor (29,5), send 0x0A -> busy=1; 80 writes of 0x20 to row 0, cols 0..79; cursor (0,0); then ready returns.
- clr pulse while req0_valid is held -> ready stays 0; 2400 consecutive writes of 0x20 ending at (29,79); cursor (0,0); a second clr mid-sweep does not add cycles.
- reset asserted in cycle 100 of CLR_ALL -> wr_en=0 and cursor (0,0) immediately; busy=0; the next char is written at (0,0).
